// File: rtl/arp_cam_lookup_ctrl.sv
// ARP IPv4->MAC table controller: direct-mapped folded-XOR hash, lookup/update arbitration, post-reset clear sweep.
// Optional hit/miss/evict counters are enabled by defining ARP_CAM_STATS_EN.
module arp_cam_lookup_ctrl #(
  parameter int A     = 9,
  parameter int KEY_W = 32,
  parameter int VAL_W = 48,
  parameter int D     = 1 + KEY_W + VAL_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             LkpReqVal,
  output logic             LkpReqRdy,
  input  logic [KEY_W-1:0] LkpReqKey,
  output logic             LkpRspVal,
  input  logic             LkpRspRdy,
  output logic             LkpRspHit,
  output logic [VAL_W-1:0] LkpRspMac,
  input  logic             UpdReqVal,
  output logic             UpdReqRdy,
  input  logic             UpdReqOp,
  input  logic [KEY_W-1:0] UpdReqKey,
  input  logic [VAL_W-1:0] UpdReqMac,
  output logic             UpdAckVal,
  output logic [1:0]       UpdAckSts,
  output logic             InitDone,
`ifdef ARP_CAM_STATS_EN
  output logic [15:0]      StatHit,
  output logic [15:0]      StatMiss,
  output logic [15:0]      StatEvict,
`endif
  output logic             RamRwEnb,
  output logic [A-1:0]     RamRwAddr,
  output logic [D-1:0]     RamRwData,
  input  logic [D-1:0]     RamRwDataOut,
  output logic             RamWrEnb,
  output logic [A-1:0]     RamWrAddr,
  output logic [D-1:0]     RamWrData
);

  localparam int NCH = (KEY_W + A - 1) / A;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LK_CMP, S_RESP, S_UP_CMP} state_t;

  state_t             state;
  logic [A-1:0]       init_cnt;
  logic               last_upd;
  logic [KEY_W-1:0]   key_q;
  logic [VAL_W-1:0]   mac_q;
  logic               op_q;
  logic [A-1:0]       addr_q;

  logic               idle, grant_lkp, grant_upd;
  logic [A-1:0]       hash_lkp, hash_upd;
  logic               w_valid, key_match, upd_wr;
  logic [KEY_W-1:0]   w_key;
  logic [VAL_W-1:0]   w_mac;
  logic [D-1:0]       upd_data;
  logic [1:0]         upd_sts;

  function automatic logic [A-1:0] fold_hash(input logic [KEY_W-1:0] key);
    logic [NCH*A-1:0] pad;
    logic [A-1:0]     h;
    pad = (NCH*A)'(key);
    h   = '0;
    for (int i = 0; i < NCH; i++) h = h ^ pad[i*A +: A];
    return h;
  endfunction

  assign hash_lkp = fold_hash(LkpReqKey);
  assign hash_upd = fold_hash(UpdReqKey);

  // When both classes request, the one not granted last time wins.
  assign idle      = (state == S_IDLE);
  assign LkpReqRdy = idle && (!UpdReqVal || last_upd);
  assign UpdReqRdy = idle && (!LkpReqVal || !last_upd);
  assign grant_lkp = LkpReqVal && LkpReqRdy;
  assign grant_upd = UpdReqVal && UpdReqRdy;

  assign RamRwEnb  = 1'b0;
  assign RamRwData = '0;
  assign RamRwAddr = grant_upd ? hash_upd : (grant_lkp ? hash_lkp : '0);

  assign w_valid   = RamRwDataOut[D-1];
  assign w_key     = RamRwDataOut[D-2:VAL_W];
  assign w_mac     = RamRwDataOut[VAL_W-1:0];
  assign key_match = w_valid && (w_key == key_q);

  always_comb begin
    upd_wr   = 1'b0;
    upd_data = '0;
    upd_sts  = 2'd0;
    if (!op_q) begin
      upd_wr   = 1'b1;
      upd_data = {1'b1, key_q, mac_q};
      upd_sts  = !w_valid ? 2'd0 : (key_match ? 2'd1 : 2'd2);
    end else if (key_match) begin
      upd_wr  = 1'b1;
      upd_sts = 2'd3;
    end
  end

  // Update writes land during UP_CMP, one edge ahead of any following read.
  always_comb begin
    RamWrEnb  = 1'b0;
    RamWrAddr = '0;
    RamWrData = '0;
    if (state == S_INIT) begin
      RamWrEnb  = 1'b1;
      RamWrAddr = init_cnt;
    end else if (state == S_UP_CMP && upd_wr) begin
      RamWrEnb  = 1'b1;
      RamWrAddr = addr_q;
      RamWrData = upd_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      last_upd  <= 1'b1;
      key_q     <= '0;
      mac_q     <= '0;
      op_q      <= 1'b0;
      addr_q    <= '0;
      LkpRspVal <= 1'b0;
      LkpRspHit <= 1'b0;
      LkpRspMac <= '0;
      UpdAckVal <= 1'b0;
      UpdAckSts <= 2'd0;
      InitDone  <= 1'b0;
    end else begin
      UpdAckVal <= 1'b0;
      UpdAckSts <= 2'd0;
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == {A{1'b1}}) begin
            state    <= S_IDLE;
            InitDone <= 1'b1;
          end
        end
        S_IDLE: begin
          if (grant_lkp) begin
            key_q    <= LkpReqKey;
            addr_q   <= hash_lkp;
            last_upd <= 1'b0;
            state    <= S_LK_CMP;
          end else if (grant_upd) begin
            key_q    <= UpdReqKey;
            mac_q    <= UpdReqMac;
            op_q     <= UpdReqOp;
            addr_q   <= hash_upd;
            last_upd <= 1'b1;
            state    <= S_UP_CMP;
          end
        end
        S_LK_CMP: begin
          LkpRspVal <= 1'b1;
          LkpRspHit <= key_match;
          LkpRspMac <= key_match ? w_mac : '0;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (LkpRspRdy) begin
            LkpRspVal <= 1'b0;
            LkpRspHit <= 1'b0;
            LkpRspMac <= '0;
            state     <= S_IDLE;
          end
        end
        S_UP_CMP: begin
          UpdAckVal <= 1'b1;
          UpdAckSts <= upd_sts;
          state     <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

`ifdef ARP_CAM_STATS_EN
  // Saturating event counters; they can only move in the compare states.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StatHit   <= '0;
      StatMiss  <= '0;
      StatEvict <= '0;
    end else begin
      if (state == S_LK_CMP) begin
        if (key_match) begin
          if (StatHit != 16'hFFFF) StatHit <= StatHit + 16'd1;
        end else begin
          if (StatMiss != 16'hFFFF) StatMiss <= StatMiss + 16'd1;
        end
      end
      if (state == S_UP_CMP && !op_q && upd_sts == 2'd2 && StatEvict != 16'hFFFF)
        StatEvict <= StatEvict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_arp_cam_lookup_ctrl.sv
// Scoreboard bench for arp_cam_lookup_ctrl: behavioural table model, RAM model, randomized and directed traffic.
// Builds with or without ARP_CAM_STATS_EN.
module tb_arp_cam_lookup_ctrl;
  localparam int A = 9, KEY_W = 32, VAL_W = 48, D = 1 + KEY_W + VAL_W, N = 1 << A;

  logic             Clk = 1'b0, Rst_n = 1'b0;
  logic             LkpReqVal = 1'b0, LkpReqRdy, LkpRspVal, LkpRspRdy = 1'b1, LkpRspHit;
  logic [KEY_W-1:0] LkpReqKey = '0, UpdReqKey = '0;
  logic [VAL_W-1:0] LkpRspMac, UpdReqMac = '0;
  logic             UpdReqVal = 1'b0, UpdReqRdy, UpdReqOp = 1'b0, UpdAckVal, InitDone;
  logic [1:0]       UpdAckSts;
  logic             RamRwEnb, RamWrEnb;
  logic [A-1:0]     RamRwAddr, RamWrAddr;
  logic [D-1:0]     RamRwData, RamRwDataOut, RamWrData;
`ifdef ARP_CAM_STATS_EN
  logic [15:0]      stat_hit, stat_miss, stat_evict;
`endif

  arp_cam_lookup_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .LkpReqVal(LkpReqVal), .LkpReqRdy(LkpReqRdy), .LkpReqKey(LkpReqKey),
    .LkpRspVal(LkpRspVal), .LkpRspRdy(LkpRspRdy), .LkpRspHit(LkpRspHit), .LkpRspMac(LkpRspMac),
    .UpdReqVal(UpdReqVal), .UpdReqRdy(UpdReqRdy), .UpdReqOp(UpdReqOp), .UpdReqKey(UpdReqKey),
    .UpdReqMac(UpdReqMac), .UpdAckVal(UpdAckVal), .UpdAckSts(UpdAckSts), .InitDone(InitDone),
`ifdef ARP_CAM_STATS_EN
    .StatHit(stat_hit), .StatMiss(stat_miss), .StatEvict(stat_evict),
`endif
    .RamRwEnb(RamRwEnb), .RamRwAddr(RamRwAddr), .RamRwData(RamRwData), .RamRwDataOut(RamRwDataOut),
    .RamWrEnb(RamWrEnb), .RamWrAddr(RamWrAddr), .RamWrData(RamWrData)
  );

  always #5 Clk = ~Clk;

  // Table RAM: registered read on the rw port, separate write-only port, power-up garbage.
  logic [D-1:0] mem [0:N-1];
  initial for (int i = 0; i < N; i++) begin
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    mem[i] = r[D-1:0];
  end
  always @(posedge Clk) begin
    RamRwDataOut <= mem[RamRwAddr];
    if (RamWrEnb) mem[RamWrAddr] <= RamWrData;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { bit hit; logic [47:0] mac; int cyc; } lkp_exp_t;
  typedef struct { logic [1:0] sts; int wr; } upd_exp_t;
  lkp_exp_t lq[$];
  upd_exp_t uq[$];

  // Reference table: one slot per hash bucket.
  bit          m_valid [N];
  logic [31:0] m_key   [N];
  logic [47:0] m_mac   [N];

  int checks = 0, passes = 0;
  bit rand_rdy = 1'b0;

  function automatic int hidx(input logic [31:0] k);
    return int'((k ^ (k >> 9) ^ (k >> 18) ^ (k >> 27)) & 32'h1FF);
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_lookup(input logic [31:0] k, input int c);
    int  i;
    bit  hit;
    i   = hidx(k);
    hit = m_valid[i] && m_key[i] == k;
    lq.push_back('{hit, hit ? m_mac[i] : 48'h0, c});
  endtask

  task automatic push_update(input bit op, input logic [31:0] k, input logic [47:0] mac);
    int i;
    i = hidx(k);
    if (!op) begin
      uq.push_back('{!m_valid[i] ? 2'd0 : (m_key[i] == k ? 2'd1 : 2'd2), 1});
      m_valid[i] = 1'b1; m_key[i] = k; m_mac[i] = mac;
    end else if (m_valid[i] && m_key[i] == k) begin
      uq.push_back('{2'd3, 1});
      m_valid[i] = 1'b0;
    end else begin
      uq.push_back('{2'd0, 0});
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard heads.
  bit prev_val = 1'b0;
  int wr_cnt = 0;
  lkp_exp_t le;
  upd_exp_t ue;
  always @(negedge Clk) begin
    #2;
    if (!Rst_n) begin
      prev_val = 1'b0;
      wr_cnt   = 0;
    end else begin
      if (InitDone && RamWrEnb) wr_cnt++;
      if (UpdAckVal) begin
        if (uq.size() == 0) check_output("unexpected_ack", 1, 0);
        else begin
          ue = uq.pop_front();
          check_output("upd_sts", UpdAckSts, ue.sts);
          check_output("upd_writes", wr_cnt, ue.wr);
        end
        wr_cnt = 0;
      end
      if (LkpRspVal) begin
        if (lq.size() == 0) check_output("unexpected_rsp", 1, 0);
        else begin
          le = lq[0];
          if (!prev_val) check_output("lkp_latency", cyc, le.cyc);
          check_output("lkp_hit", LkpRspHit, le.hit);
          check_output("lkp_mac", LkpRspMac, le.mac);
          if (LkpRspRdy) void'(lq.pop_front());
        end
      end
      prev_val = LkpRspVal;
    end
  end

  // One clock of driving: entered and left at a falling edge.
  task automatic step(output bit la, output bit ua);
    if (rand_rdy) LkpRspRdy = 1'($urandom_range(0, 1));
    #1;
    la = LkpReqVal && LkpReqRdy;
    ua = UpdReqVal && UpdReqRdy;
    if (la) push_lookup(LkpReqKey, cyc + 2);
    if (ua) push_update(UpdReqOp, UpdReqKey, UpdReqMac);
    @(negedge Clk);
  endtask

  task automatic apply_stimulus(input bit dl, input logic [31:0] lk, input bit du, input bit op,
                                input logic [31:0] uk, input logic [47:0] mac);
    bit la, ua;
    int n = 0;
    LkpReqVal = dl; LkpReqKey = lk;
    UpdReqVal = du; UpdReqOp = op; UpdReqKey = uk; UpdReqMac = mac;
    while ((LkpReqVal || UpdReqVal) && n < 200) begin
      step(la, ua);
      if (la) LkpReqVal = 1'b0;
      if (ua) UpdReqVal = 1'b0;
      n++;
    end
    if (LkpReqVal || UpdReqVal) begin
      check_output("accept_timeout", n, 0);
      LkpReqVal = 1'b0; UpdReqVal = 1'b0;
    end
  endtask

  task automatic drain();
    bit la, ua;
    int n = 0;
    while ((lq.size() != 0 || uq.size() != 0) && n < 500) begin
      step(la, ua);
      n++;
    end
    check_output("drain_pending", lq.size() + uq.size(), 0);
  endtask

  task automatic assert_reset();
    Rst_n = 1'b0;
    #1;
    lq.delete(); uq.delete();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    check_output("reset_outputs", {LkpRspVal, UpdAckVal, InitDone, LkpReqRdy, UpdReqRdy}, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    check_output("sweep_start_addr", RamWrAddr, 0);
  endtask

  task automatic wait_init();
    int n = 0;
    bit rdy_bad = 1'b0, we_bad = 1'b0;
    while (!InitDone && n < 1000) begin
      if (LkpReqRdy || UpdReqRdy) rdy_bad = 1'b1;
      if (!RamWrEnb) we_bad = 1'b1;
      @(posedge Clk); #1;
      n++;
    end
    @(negedge Clk);
    check_output("init_cycles", n, 512);
    check_output("init_rdy_low", rdy_bad, 0);
    check_output("init_wr_enb", we_bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit la, ua, grant_seen, stable, cap_hit;
    logic [47:0] cap_mac;
    int n, g;

    @(negedge Clk);
    assert_reset();
    wait_init();

    // Directed: miss, insert/hit, collision eviction, delete cases.
    apply_stimulus(1, 32'h0A000001, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 32'h0A000001, 48'h001122334455);
    apply_stimulus(1, 32'h0A000001, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 32'h00000001, 48'hA1A1A1A1A1A1);
    apply_stimulus(0, 0, 1, 0, 32'h00000200, 48'hB2B2B2B2B2B2);
    apply_stimulus(1, 32'h00000001, 0, 0, 0, 0);
    apply_stimulus(1, 32'h00000200, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 1, 32'h00000005, 0);
    apply_stimulus(0, 0, 1, 0, 32'h00000005, 48'hC3C3C3C3C3C3);
    apply_stimulus(0, 0, 1, 1, 32'h00000005, 0);
    apply_stimulus(1, 32'h00000005, 0, 0, 0, 0);
    drain();

    // Back-pressured response: held stable, nothing granted meanwhile.
    LkpRspRdy = 1'b0;
    apply_stimulus(1, 32'h0A000001, 0, 0, 0, 0);
    UpdReqVal = 1'b1; UpdReqOp = 1'b0; UpdReqKey = 32'h0A000001; UpdReqMac = 48'hDEADBEEF0001;
    n = 0;
    grant_seen = 1'b0;
    while (!LkpRspVal && n < 20) begin step(la, ua); grant_seen |= ua; n++; end
    cap_hit = LkpRspHit; cap_mac = LkpRspMac;
    stable = LkpRspVal;
    repeat (5) begin
      step(la, ua);
      grant_seen |= ua;
      if (!(LkpRspVal && LkpRspHit == cap_hit && LkpRspMac == cap_mac)) stable = 1'b0;
    end
    check_output("resp_no_grant", grant_seen, 0);
    check_output("resp_stable", stable, 1);
    LkpRspRdy = 1'b1;
    n = 0;
    while (UpdReqVal && n < 50) begin step(la, ua); if (ua) UpdReqVal = 1'b0; n++; end
    check_output("held_upd_accepted", UpdReqVal, 0);
    UpdReqVal = 1'b0;
    apply_stimulus(1, 32'h0A000001, 0, 0, 0, 0);
    drain();

    // Random traffic over a small key pool so buckets collide often.
    rand_rdy = 1'b1;
    repeat (300) begin
      logic [31:0] k1, k2;
      int kind;
      k1 = 32'($urandom_range(0, 7)) | (32'($urandom_range(0, 3)) << 9);
      k2 = 32'($urandom_range(0, 7)) | (32'($urandom_range(0, 3)) << 9);
      kind = $urandom_range(0, 3);
      apply_stimulus(kind == 0 || kind == 3, k1, kind != 0, $urandom_range(0, 2) == 0, k2,
                     {$urandom, 16'($urandom)});
    end
    drain();
    rand_rdy = 1'b0;
    LkpRspRdy = 1'b1;

    // Reset in the middle of the sweep, then a full sweep again.
    assert_reset();
    repeat (100) @(negedge Clk);
    check_output("sweep_addr_100", RamWrAddr, 100);
    assert_reset();
    wait_init();

    // Reset while a response is parked in RESP.
    apply_stimulus(0, 0, 1, 0, 32'h0A000001, 48'h001122334455);
    drain();
    LkpRspRdy = 1'b0;
    apply_stimulus(1, 32'h0A000001, 0, 0, 0, 0);
    n = 0;
    while (!LkpRspVal && n < 20) begin step(la, ua); n++; end
    check_output("resp_before_reset", LkpRspVal, 1);
    assert_reset();
    wait_init();
    LkpRspRdy = 1'b1;

    // Both request classes held high: lookup first after reset, then strict alternation.
    LkpReqVal = 1'b1; LkpReqKey = 32'h0A000001;
    UpdReqVal = 1'b1; UpdReqOp = 1'b0; UpdReqKey = 32'h0A000001; UpdReqMac = 48'h665544332211;
    g = 0; n = 0;
    while (g < 6 && n < 100) begin
      step(la, ua);
      if (la || ua) begin
        check_output("arb_order", ua, g % 2);
        g++;
      end
      n++;
    end
    check_output("arb_grants", g, 6);
    LkpReqVal = 1'b0; UpdReqVal = 1'b0;
    drain();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
